// File: rtl/atp_card_pin_authenticator.sv
// ATP card/PIN authenticator: card detect, ID latch, PIN check with retry limit, lockout and timeout.
// Optional customer-ID blacklist is built when ATP_AUTH_BLACKLIST_EN is defined.
module atp_card_pin_authenticator #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 39062
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       card_inserted,
    input  logic [7:0] card_data,
    input  logic [3:0] expected_pin,
    input  logic [3:0] pin,
    input  logic       pin_valid,
    input  logic       session_done,
    output logic [7:0] customer_id,
    output logic       authorized,
    output logic       auth_fail,
    output logic       card_locked,
    output logic       auth_timeout,
    output logic [1:0] attempts_left
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CARD_READ = 3'd1,
        S_WAIT_PIN  = 3'd2,
        S_CHECK     = 3'd3,
        S_AUTH_OK   = 3'd4,
        S_LOCKED    = 3'd5,
        S_EJECT     = 3'd6
    } state_t;

    localparam logic [1:0]  MAX_ATT    = 2'(MAX_ATTEMPTS);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] timer_r;
    logic [15:0] timer_nxt_s;
    logic [3:0]  pin_r;
    logic [3:0]  pin_nxt_s;
    logic [7:0]  customer_id_r;
    logic [7:0]  customer_id_nxt_s;
    logic [1:0]  attempts_r;
    logic [1:0]  attempts_nxt_s;
    logic        authorized_r;
    logic        authorized_nxt_s;
    logic        card_locked_r;
    logic        card_locked_nxt_s;
    logic        auth_fail_r;
    logic        auth_fail_nxt_s;
    logic        auth_timeout_r;
    logic        auth_timeout_nxt_s;

    logic        pin_match_s;
    logic        timer_done_s;
    logic [1:0]  attempts_dec_s;
    logic        bl_hit_s;

    assign pin_match_s    = (pin_r == expected_pin);
    assign timer_done_s   = (timer_r == TIMER_LAST);
    assign attempts_dec_s = (attempts_r == 2'd0) ? 2'd0 : (attempts_r - 2'd1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; card removal always wins over keypad and timeout
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (card_inserted) state_nxt_s = S_CARD_READ;
                else               state_nxt_s = S_IDLE;
            end
            S_CARD_READ: begin
                if (bl_hit_s) state_nxt_s = S_LOCKED;
                else          state_nxt_s = S_WAIT_PIN;
            end
            S_WAIT_PIN: begin
                if (!card_inserted)    state_nxt_s = S_IDLE;
                else if (pin_valid)    state_nxt_s = S_CHECK;
                else if (timer_done_s) state_nxt_s = S_EJECT;
                else                   state_nxt_s = S_WAIT_PIN;
            end
            S_CHECK: begin
                if (pin_match_s)                 state_nxt_s = S_AUTH_OK;
                else if (attempts_dec_s == 2'd0) state_nxt_s = S_LOCKED;
                else                             state_nxt_s = S_WAIT_PIN;
            end
            S_AUTH_OK: begin
                if (!card_inserted)    state_nxt_s = S_IDLE;
                else if (session_done) state_nxt_s = S_EJECT;
                else                   state_nxt_s = S_AUTH_OK;
            end
            S_LOCKED: begin
                if (!card_inserted) state_nxt_s = S_IDLE;
                else                state_nxt_s = S_LOCKED;
            end
            S_EJECT: begin
                if (!card_inserted) state_nxt_s = S_IDLE;
                else                state_nxt_s = S_EJECT;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output/datapath decode; levels follow the destination state so they change on the entry edge
    always_comb begin
        timer_nxt_s        = timer_r;
        pin_nxt_s          = pin_r;
        customer_id_nxt_s  = customer_id_r;
        attempts_nxt_s     = attempts_r;
        auth_fail_nxt_s    = 1'b0;
        auth_timeout_nxt_s = 1'b0;
        authorized_nxt_s   = (state_nxt_s == S_AUTH_OK);
        card_locked_nxt_s  = (state_nxt_s == S_LOCKED);
        case (state_r)
            S_IDLE: begin
                if (card_inserted) customer_id_nxt_s = card_data;
                else               customer_id_nxt_s = customer_id_r;
            end
            S_CARD_READ: begin
                timer_nxt_s = 16'd0;
                if (bl_hit_s) attempts_nxt_s = 2'd0;
                else          attempts_nxt_s = MAX_ATT;
            end
            S_WAIT_PIN: begin
                if (!card_inserted) begin
                    timer_nxt_s = timer_r;
                end else if (pin_valid) begin
                    pin_nxt_s   = pin;
                    timer_nxt_s = 16'd0;
                end else if (timer_done_s) begin
                    auth_timeout_nxt_s = 1'b1;
                end else begin
                    timer_nxt_s = (timer_r == 16'hFFFF) ? timer_r : (timer_r + 16'd1);
                end
            end
            S_CHECK: begin
                if (pin_match_s) begin
                    attempts_nxt_s = attempts_r;
                end else begin
                    auth_fail_nxt_s = 1'b1;
                    attempts_nxt_s  = attempts_dec_s;
                    timer_nxt_s     = 16'd0;
                end
            end
            default: begin
                timer_nxt_s = timer_r;
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r        <= 16'd0;
            pin_r          <= 4'd0;
            customer_id_r  <= 8'd0;
            attempts_r     <= MAX_ATT;
            authorized_r   <= 1'b0;
            card_locked_r  <= 1'b0;
            auth_fail_r    <= 1'b0;
            auth_timeout_r <= 1'b0;
        end else begin
            timer_r        <= timer_nxt_s;
            pin_r          <= pin_nxt_s;
            customer_id_r  <= customer_id_nxt_s;
            attempts_r     <= attempts_nxt_s;
            authorized_r   <= authorized_nxt_s;
            card_locked_r  <= card_locked_nxt_s;
            auth_fail_r    <= auth_fail_nxt_s;
            auth_timeout_r <= auth_timeout_nxt_s;
        end
    end

`ifdef ATP_AUTH_BLACKLIST_EN
    logic [7:0] bl_id_r [4];
    logic [3:0] bl_valid_r;
    logic [1:0] bl_wptr_r;
    logic       bl_write_s;

    // Only PIN-driven lockouts are recorded; a blacklist hit is already stored
    assign bl_write_s = (state_r == S_CHECK) && (state_nxt_s == S_LOCKED);

    // Blacklist lookup against the latched customer ID
    always_comb begin
        bl_hit_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bl_hit_s = bl_hit_s | (bl_valid_r[i] && (bl_id_r[i] == customer_id_r));
        end
    end

    // Blacklist storage, oldest entry replaced when full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                bl_id_r[i] <= 8'd0;
            end
            bl_valid_r <= 4'd0;
            bl_wptr_r  <= 2'd0;
        end else if (bl_write_s) begin
            bl_id_r[bl_wptr_r]    <= customer_id_r;
            bl_valid_r[bl_wptr_r] <= 1'b1;
            bl_wptr_r             <= bl_wptr_r + 2'd1;
        end else begin
            bl_wptr_r <= bl_wptr_r;
        end
    end
`else
    assign bl_hit_s = 1'b0;
`endif

    assign customer_id   = customer_id_r;
    assign authorized    = authorized_r;
    assign auth_fail     = auth_fail_r;
    assign card_locked   = card_locked_r;
    assign auth_timeout  = auth_timeout_r;
    assign attempts_left = attempts_r;

endmodule

// File: tb/tb_atp_card_pin_authenticator.sv
// Directed self-checking bench for atp_card_pin_authenticator (timeout shortened to 100 cycles).
module tb_atp_card_pin_authenticator;

    logic       clk;
    logic       reset_n;
    logic       card_inserted;
    logic [7:0] card_data;
    logic [3:0] expected_pin;
    logic [3:0] pin;
    logic       pin_valid;
    logic       session_done;
    logic [7:0] customer_id;
    logic       authorized;
    logic       auth_fail;
    logic       card_locked;
    logic       auth_timeout;
    logic [1:0] attempts_left;

    int n_assert = 0;
    int n_fail   = 0;

    atp_card_pin_authenticator #(
        .MAX_ATTEMPTS   (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .card_inserted (card_inserted),
        .card_data     (card_data),
        .expected_pin  (expected_pin),
        .pin           (pin),
        .pin_valid     (pin_valid),
        .session_done  (session_done),
        .customer_id   (customer_id),
        .authorized    (authorized),
        .auth_fail     (auth_fail),
        .card_locked   (card_locked),
        .auth_timeout  (auth_timeout),
        .attempts_left (attempts_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic press(input logic [3:0] value);
        pin       = value;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset_n       = 1'b0;
        card_inserted = 1'b0;
        card_data     = 8'h00;
        expected_pin  = 4'h0;
        pin           = 4'h0;
        pin_valid     = 1'b0;
        session_done  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cid", 32'(customer_id), 32'h00);
        chk("rst_auth", 32'(authorized), 32'h0);
        chk("rst_fail", 32'(auth_fail), 32'h0);
        chk("rst_lock", 32'(card_locked), 32'h0);
        chk("rst_tmo", 32'(auth_timeout), 32'h0);
        chk("rst_att", 32'(attempts_left), 32'h3);
        reset_n = 1'b1;
        tick();
        chk("idle_auth", 32'(authorized), 32'h0);

        // Correct PIN
        card_data     = 8'h5A;
        expected_pin  = 4'h7;
        card_inserted = 1'b1;
        tick();
        chk("ok_cid", 32'(customer_id), 32'h5A);
        tick();
        chk("ok_att", 32'(attempts_left), 32'h3);
        pin       = 4'h7;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        chk("ok_auth_1cyc", 32'(authorized), 32'h0);
        tick();
        chk("ok_auth_2cyc", 32'(authorized), 32'h1);
        chk("ok_nofail", 32'(auth_fail), 32'h0);
        press(4'h1);
        chk("ok_kpd_ignored_auth", 32'(authorized), 32'h1);
        chk("ok_kpd_ignored_fail", 32'(auth_fail), 32'h0);
        session_done = 1'b1;
        tick();
        session_done = 1'b0;
        chk("done_auth", 32'(authorized), 32'h0);
        press(4'h7);
        tick();
        chk("eject_no_restart", 32'(authorized), 32'h0);
        chk("eject_cid", 32'(customer_id), 32'h5A);
        card_inserted = 1'b0;
        tick();

        // Wrong PIN twice, then correct
        card_data     = 8'h21;
        expected_pin  = 4'h4;
        card_inserted = 1'b1;
        tick();
        chk("retry_cid", 32'(customer_id), 32'h21);
        tick();
        press(4'h1);
        chk("retry_fail1", 32'(auth_fail), 32'h1);
        chk("retry_att2", 32'(attempts_left), 32'h2);
        tick();
        chk("retry_fail1_pulse", 32'(auth_fail), 32'h0);
        press(4'h2);
        chk("retry_fail2", 32'(auth_fail), 32'h1);
        chk("retry_att1", 32'(attempts_left), 32'h1);
        tick();
        chk("retry_fail2_pulse", 32'(auth_fail), 32'h0);
        press(4'h4);
        chk("retry_auth", 32'(authorized), 32'h1);
        chk("retry_att_kept", 32'(attempts_left), 32'h1);
        card_inserted = 1'b0;
        tick();
        chk("retry_remove_auth", 32'(authorized), 32'h0);

        // Three wrong PINs -> lockout
        card_data     = 8'h33;
        expected_pin  = 4'h9;
        card_inserted = 1'b1;
        tick();
        tick();
        chk("lock_att3", 32'(attempts_left), 32'h3);
        press(4'h0);
        tick();
        press(4'h1);
        tick();
        press(4'h2);
        chk("lock_fail3", 32'(auth_fail), 32'h1);
        chk("lock_att0", 32'(attempts_left), 32'h0);
        chk("lock_locked", 32'(card_locked), 32'h1);
        chk("lock_noauth", 32'(authorized), 32'h0);
        tick();
        chk("lock_fail_pulse", 32'(auth_fail), 32'h0);
        press(4'h9);
        chk("lock_kpd_locked", 32'(card_locked), 32'h1);
        chk("lock_kpd_auth", 32'(authorized), 32'h0);
        chk("lock_kpd_fail", 32'(auth_fail), 32'h0);
        chk("lock_kpd_att", 32'(attempts_left), 32'h0);
        card_inserted = 1'b0;
        tick();
        chk("unlock", 32'(card_locked), 32'h0);

        // Reinsert the locked ID
        card_inserted = 1'b1;
        tick();
        tick();
`ifdef ATP_AUTH_BLACKLIST_EN
        chk("bl_locked", 32'(card_locked), 32'h1);
        chk("bl_att", 32'(attempts_left), 32'h0);
`else
        chk("relock_fresh", 32'(card_locked), 32'h0);
        chk("relock_att", 32'(attempts_left), 32'h3);
`endif
        card_inserted = 1'b0;
        tick();

        // Inactivity timeout
        card_data     = 8'h44;
        card_inserted = 1'b1;
        tick();
        tick();
        repeat (99) tick();
        chk("tmo_early", 32'(auth_timeout), 32'h0);
        tick();
        chk("tmo_pulse", 32'(auth_timeout), 32'h1);
        chk("tmo_noauth", 32'(authorized), 32'h0);
        tick();
        chk("tmo_pulse_end", 32'(auth_timeout), 32'h0);
        card_inserted = 1'b0;
        tick();
        card_data     = 8'h55;
        card_inserted = 1'b1;
        tick();
        chk("tmo_back_idle", 32'(customer_id), 32'h55);

        // Card removed with pin_valid in the same cycle
        expected_pin = 4'h3;
        tick();
        card_inserted = 1'b0;
        pin           = 4'h3;
        pin_valid     = 1'b1;
        tick();
        pin_valid = 1'b0;
        tick();
        chk("rm_noauth", 32'(authorized), 32'h0);
        chk("rm_nofail", 32'(auth_fail), 32'h0);
        card_data     = 8'h66;
        card_inserted = 1'b1;
        tick();
        chk("rm_idle", 32'(customer_id), 32'h66);

        // Asynchronous reset while authorized
        tick();
        press(4'h3);
        chk("ar_auth", 32'(authorized), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_async_auth", 32'(authorized), 32'h0);
        chk("ar_async_cid", 32'(customer_id), 32'h00);
        tick();
        reset_n       = 1'b1;
        card_inserted = 1'b0;
        tick();
        chk("ar_after_auth", 32'(authorized), 32'h0);
        chk("ar_after_att", 32'(attempts_left), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/atp_card_pin_authenticator.md
Name: atp_card_pin_authenticator

Overview:
- Upstream stage of the ATP electricity-bill payment controller: detects card insertion, latches the customer ID and checks the keypad PIN against the account PIN.
- Enforces a retry limit, lockout and an inactivity timeout.
- Presents a stable customer_id plus a level `authorized` that the payment stage consumes, held until that stage reports session_done.

Parameters:
- MAX_ATTEMPTS, 3, PIN tries before lockout (1..3; attempt counter is 2 bits).
- TIMEOUT_CYCLES, 39062, idle cycles in WAIT_PIN before timeout (counter 16 bits).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- card_inserted  input  1  level, high while a card is in the slot
- card_data  input  8  customer ID read from the card
- expected_pin  input  4  account PIN for customer_id, from account store, valid one cycle after customer_id changes
- pin  input  4  keypad PIN digit group
- pin_valid  input  1  one-cycle strobe, pin is valid
- session_done  input  1  one-cycle strobe from payment stage, transaction finished
- customer_id  output  8  latched card_data
- authorized  output  1  level, PIN accepted and session open
- auth_fail  output  1  one-cycle pulse per wrong PIN
- card_locked  output  1  level, lockout active
- auth_timeout  output  1  one-cycle pulse on inactivity timeout
- attempts_left  output  2  remaining tries

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE.
  - customer_id=0, authorized=0, auth_fail=0, card_locked=0, auth_timeout=0.
  - attempts_left=MAX_ATTEMPTS, timer=0.
- IDLE:
  - card_inserted=1 -> CARD_READ; customer_id<=card_data that same edge.
- CARD_READ, 1 cycle for the account-store lookup:
  - -> WAIT_PIN; timer<=0; attempts_left<=MAX_ATTEMPTS.
- WAIT_PIN:
  - pin_valid=1 -> CHECK; pin is registered; timer<=0.
  - Else timer increments. At timer==TIMEOUT_CYCLES-1 -> EJECT with auth_timeout pulsed 1 cycle.
  - card_inserted=0 at any point -> IDLE, with no pulses. Card removal has priority over pin_valid and over the timeout.
- CHECK, 1 cycle:
  - Registered pin==expected_pin -> AUTH_OK; authorized<=1 on entry.
  - Mismatch: auth_fail pulses 1 cycle and attempts_left decrements.
    - If the decremented value is 0 -> LOCKED.
    - Else -> WAIT_PIN with timer<=0.
- AUTH_OK:
  - authorized held high.
  - session_done=1 -> EJECT; authorized<=0 the same edge.
  - card_inserted=0 -> IDLE; authorized<=0 the same edge.
  - pin_valid is ignored.
- LOCKED:
  - card_locked=1 and authorized=0.
  - Stays until card_inserted=0, then -> IDLE with card_locked<=0.
  - Keypad is ignored.
- EJECT:
  - Waits for card_inserted=0, then -> IDLE.
  - Holding the card in does not restart a session. A new session needs a rising edge of card_inserted.
- Pulse outputs are registered, high for exactly one cycle, and never overlap.
- authorized and card_locked are never both 1.
- The timer saturates and does not wrap. attempts_left never underflows.
- Latency:
  - card_inserted edge to WAIT_PIN: 2 cycles.
  - pin_valid to authorized or auth_fail: 2 cycles, i.e. the capture edge plus the CHECK edge.
- Reset mid-session clears authorized immediately, asynchronously.
- Unused state encodings -> IDLE.

Optional Feature:
- Macro ATP_AUTH_BLACKLIST_EN.
- When defined:
  - A 4-entry FIFO-replacement blacklist of customer IDs is added; it is cleared by reset.
  - Entering LOCKED writes customer_id into the next slot, overwriting the oldest entry when full.
  - In CARD_READ, a match against any valid entry goes directly to LOCKED with attempts_left=0 and no PIN prompt.
- When undefined:
  - No blacklist storage exists.
  - A locked card gets a fresh MAX_ATTEMPTS on its next insertion.

Test Plan:
- Correct PIN: card_data=0x5A, expected_pin=4'h7, pin=7 with pin_valid.
  - Expected: authorized=1 two cycles after the strobe; customer_id=0x5A.
  - session_done -> authorized=0 and state EJECT.
- Wrong PIN twice, then correct.
  - Expected: two auth_fail pulses, attempts_left 3->2->1, then authorized=1.
- Three wrong PINs.
  - Expected: attempts_left=0 and card_locked=1.
  - card_inserted=0 -> card_locked=0 and state IDLE.
- No keypad input for TIMEOUT_CYCLES (override to 100).
  - Expected: auth_timeout pulses at cycle 100 of WAIT_PIN; authorized stays 0; return to IDLE on card removal.
- Card removed the same cycle as pin_valid.
  - Expected: state IDLE, with no auth_fail and no authorized.
- Reset_n asserted while authorized=1.
  - Expected: authorized=0 immediately, asynchronously.
- Blacklist (ATP_AUTH_BLACKLIST_EN): lock ID 0x33, then reinsert 0x33.
  - Expected: card_locked=1 two cycles after insertion.
